report_packer: RTL and testbench
================================

REPORT_PACKER -- requirements
Module: report_packer

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 4, sample/bin width.
REQ-002 SHALL have parameter LENGTH, default 64, samples per frame.
REQ-003 SHALL have parameter LENGTH_SIZE, default 6, frame address / count width.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 FramEn  in  1  frame sample valid.
REQ-007 FramAdd  in  LENGTH_SIZE  frame sample index.
REQ-008 FramData  in  DATA_SIZE  frame sample value.
REQ-009 SortValid  in  1  one-cycle pulse; top-3 results valid.
REQ-010 MaxCountData1..3  in  DATA_SIZE each  top-3 bin values, rank 1 first.
REQ-011 MaxCount1..3  in  LENGTH_SIZE each  top-3 bin counts.
REQ-012 TxData  out  8  packet byte.
REQ-013 TxValid  out  1  TxData valid.
REQ-014 TxReady  in  1  consumer accepts the byte.
REQ-015 TxLast  out  1  marks the final (checksum) byte.
REQ-016 Busy  out  1  packet transmission in progress.
REQ-017 Overrun  out  1  sticky: input arrived during transmission.

Function
REQ-018 States: IDLE, HDR, RES, FRM, CHK.
- In IDLE: FramEn writes FramData to buffer[FramAdd].
- FramEn with FramAdd==LENGTH-1 sets FrameDone.
- SortValid registers all six result inputs and sets SortDone.
REQ-019 FrameDone and SortDone SHALL be accepted in either order.
- Set on the same edge: both are accepted.
- A partial frame (address LENGTH-1 never written) SHALL NOT set FrameDone.
- A repeated SortValid before transmission overwrites the results.
REQ-020 Start of transmission:
- At the edge after both flags are set: enter HDR, clear both flags, raise TxValid and Busy.
- Latency is one cycle from flag-set to TxValid.
REQ-021 Packet byte order, 40 bytes when LENGTH=64:
- 0xA5.
- Six result bytes: {0,Data1}, {0,Count1}, {0,Data2}, {0,Count2}, {0,Data3}, {0,Count3}, zero-extended to 8 bits.
- LENGTH/2 frame bytes: byte k = {sample[2k+1], sample[2k]}.
- Checksum byte.
REQ-022 Checksum:
- XOR of all preceding packet bytes, header included.
- Accumulated on accepted bytes only.
REQ-023 Handshake:
- A byte is transferred on an edge where TxValid && TxReady.
- TxData and TxLast SHALL hold stable while TxValid && !TxReady.
- TxValid SHALL NOT drop until the byte is transferred.
REQ-024 TxValid SHALL stay high continuously from the HDR byte to the CHK byte, with no bubbles when TxReady is held high.
REQ-025 TxLast SHALL be high only with the CHK byte.
REQ-026 After the CHK byte transfers:
- Return to IDLE the next cycle; TxValid and Busy go low.
- The next capture may start on that same edge.
REQ-027 While not in IDLE:
- FramEn and SortValid SHALL be ignored; the buffer, results and flags are unchanged.
- Either input asserted SHALL set Overrun, which stays high until rst.
REQ-028 The byte and frame-pair counters SHALL wrap only under FSM control. A counter reaching its terminal value SHALL advance the state.

Reset
REQ-029 On rst, at the same clock edge, all of the following SHALL be 0: TxValid, TxLast, Busy, Overrun, FrameDone, SortDone, counters and checksum; state is IDLE; TxData is 0x00.
REQ-030 Reset mid-packet SHALL abort the packet; no resumption.
REQ-031 Buffer contents are undefined after reset; they need not be cleared.

Structure
REQ-032 Shared package report_pkg SHALL hold:
- HDR_BYTE = 8'hA5.
- RES_BYTES = 6.
- the state enumeration.
- PKT_BYTES = 8 + LENGTH/2.
REQ-033 Sub-module report_frame_buf SHALL provide:
- LENGTH x DATA_SIZE storage.
- Single write port.
- Combinational paired-sample read returning {sample[2k+1], sample[2k]}.

Verification
REQ-034 Frame all zeros; results (3,10),(5,8),(0,0); TxReady=1:
- Bytes A5,03,0A,05,08,00,00, 32x00, A1.
- TxLast only on A1.
- 40 consecutive TxValid cycles.
REQ-035 Frame sample[i]=i mod 16, SortValid arriving before the frame ends:
- Frame bytes 10,32,54,...,FE repeated.
- Packet starts 1 cycle after the FramAdd=63 write.
REQ-036 TxReady toggling 1,0,0,1 during the packet:
- TxData is held across stalls.
- Byte sequence is identical to REQ-034.
REQ-037 SortValid on the same edge as the FramAdd=63 write:
- Packet starts the next cycle.
- A FramEn pulse during FRM sets Overrun=1, and the packet bytes are unchanged.
REQ-038 rst asserted at byte 20, then a fresh frame and results:
- TxValid=0 and Busy=0 the cycle after rst.
- The new packet is complete and correct.
- A frame stopping at FramAdd=40 yields no packet.

Source files
------------

// File: rtl/report_pkg.sv
// Shared constants and FSM state encoding for the report packer.
// Packet layout: header, six result bytes, LENGTH/2 frame bytes, checksum.
package report_pkg;

    localparam logic [7:0] HDR_BYTE   = 8'hA5;
    localparam int         RES_BYTES  = 6;
    localparam int         DEF_LENGTH = 64;
    localparam int         PKT_BYTES  = 8 + DEF_LENGTH / 2;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        RES,
        FRM,
        CHK
    } state_t;

endpackage

// File: rtl/report_frame_buf.sv
// Frame sample store: single write port, combinational read of an adjacent
// sample pair packed as {sample[2k+1], sample[2k]}.
module report_frame_buf
    import report_pkg::*;
#(
    parameter int DATA_SIZE   = 4,
    parameter int LENGTH      = 64,
    parameter int LENGTH_SIZE = 6
) (
    input  logic                   clk,
    input  logic                   i_wr_en,
    input  logic [LENGTH_SIZE-1:0] i_wr_addr,
    input  logic [DATA_SIZE-1:0]   i_wr_data,
    input  logic [LENGTH_SIZE-2:0] i_rd_pair,
    output logic [2*DATA_SIZE-1:0] o_rd_data
);

    logic [DATA_SIZE-1:0] r_mem [LENGTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = {r_mem[{i_rd_pair, 1'b1}], r_mem[{i_rd_pair, 1'b0}]};

endmodule

// File: rtl/report_packer.sv
// Captures a frame and top-3 sort results, then streams them as a
// checksummed byte packet over a valid/ready interface.
module report_packer
    import report_pkg::*;
#(
    parameter int DATA_SIZE   = 4,
    parameter int LENGTH      = 64,
    parameter int LENGTH_SIZE = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   FramEn,
    input  logic [LENGTH_SIZE-1:0] FramAdd,
    input  logic [DATA_SIZE-1:0]   FramData,
    input  logic                   SortValid,
    input  logic [DATA_SIZE-1:0]   MaxCountData1,
    input  logic [DATA_SIZE-1:0]   MaxCountData2,
    input  logic [DATA_SIZE-1:0]   MaxCountData3,
    input  logic [LENGTH_SIZE-1:0] MaxCount1,
    input  logic [LENGTH_SIZE-1:0] MaxCount2,
    input  logic [LENGTH_SIZE-1:0] MaxCount3,
    output logic [7:0]             TxData,
    output logic                   TxValid,
    input  logic                   TxReady,
    output logic                   TxLast,
    output logic                   Busy,
    output logic                   Overrun
);

    localparam int                     PAIR_W    = LENGTH_SIZE - 1;
    localparam logic [PAIR_W-1:0]      LAST_PAIR = PAIR_W'(LENGTH / 2 - 1);
    localparam logic [LENGTH_SIZE-1:0] LAST_ADDR = LENGTH_SIZE'(LENGTH - 1);
    localparam logic [2:0]             LAST_RES  = 3'(RES_BYTES - 1);

    state_t                 r_state;
    logic                   r_frame_done;
    logic                   r_sort_done;
    logic                   r_overrun;
    logic [DATA_SIZE-1:0]   r_data1, r_data2, r_data3;
    logic [LENGTH_SIZE-1:0] r_count1, r_count2, r_count3;
    logic [7:0]             r_tx_data;
    logic                   r_tx_valid;
    logic                   r_tx_last;
    logic                   r_busy;
    logic [2:0]             r_res_cnt;
    logic [PAIR_W-1:0]      r_pair_cnt;
    logic [7:0]             r_chk;

    logic                   w_xfer;
    logic                   w_start;
    logic                   w_capture;
    logic                   w_wr_en;
    logic [PAIR_W-1:0]      w_rd_idx;
    logic [2*DATA_SIZE-1:0] w_pair;
    logic [7:0]             w_pair_byte;
    logic [7:0]             w_res_next;

    assign w_xfer  = r_tx_valid && TxReady;
    assign w_start = (r_state == IDLE) && r_frame_done && r_sort_done;
    // Capture is open in IDLE and on the edge the checksum byte leaves.
    assign w_capture = ((r_state == IDLE) && !w_start) || ((r_state == CHK) && w_xfer);
    assign w_wr_en   = w_capture && FramEn;

    // Read port looks one pair ahead so the next byte is ready at transfer.
    assign w_rd_idx    = (r_state == FRM) ? r_pair_cnt + 1'b1 : '0;
    assign w_pair_byte = 8'(w_pair);

    report_frame_buf #(
        .DATA_SIZE  (DATA_SIZE),
        .LENGTH     (LENGTH),
        .LENGTH_SIZE(LENGTH_SIZE)
    ) u_buf (
        .clk      (clk),
        .i_wr_en  (w_wr_en),
        .i_wr_addr(FramAdd),
        .i_wr_data(FramData),
        .i_rd_pair(w_rd_idx),
        .o_rd_data(w_pair)
    );

    always_comb begin
        w_res_next = 8'h00;
        case (r_res_cnt)
            3'd0:    w_res_next = 8'(r_count1);
            3'd1:    w_res_next = 8'(r_data2);
            3'd2:    w_res_next = 8'(r_count2);
            3'd3:    w_res_next = 8'(r_data3);
            3'd4:    w_res_next = 8'(r_count3);
            default: w_res_next = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (SortValid && w_capture) begin
            r_data1  <= MaxCountData1;
            r_data2  <= MaxCountData2;
            r_data3  <= MaxCountData3;
            r_count1 <= MaxCount1;
            r_count2 <= MaxCount2;
            r_count3 <= MaxCount3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_frame_done <= 1'b0;
            r_sort_done  <= 1'b0;
            r_overrun    <= 1'b0;
            r_tx_data    <= 8'h00;
            r_tx_valid   <= 1'b0;
            r_tx_last    <= 1'b0;
            r_busy       <= 1'b0;
            r_res_cnt    <= '0;
            r_pair_cnt   <= '0;
            r_chk        <= 8'h00;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state      <= HDR;
                        r_frame_done <= 1'b0;
                        r_sort_done  <= 1'b0;
                        r_tx_data    <= HDR_BYTE;
                        r_tx_valid   <= 1'b1;
                        r_tx_last    <= 1'b0;
                        r_busy       <= 1'b1;
                        r_chk        <= 8'h00;
                        r_res_cnt    <= '0;
                        r_pair_cnt   <= '0;
                    end
                end
                HDR: begin
                    if (w_xfer) begin
                        r_chk     <= r_chk ^ r_tx_data;
                        r_state   <= RES;
                        r_res_cnt <= '0;
                        r_tx_data <= 8'(r_data1);
                    end
                end
                RES: begin
                    if (w_xfer) begin
                        r_chk <= r_chk ^ r_tx_data;
                        if (r_res_cnt == LAST_RES) begin
                            r_state    <= FRM;
                            r_res_cnt  <= '0;
                            r_pair_cnt <= '0;
                            r_tx_data  <= w_pair_byte;
                        end else begin
                            r_res_cnt <= r_res_cnt + 1'b1;
                            r_tx_data <= w_res_next;
                        end
                    end
                end
                FRM: begin
                    if (w_xfer) begin
                        r_chk <= r_chk ^ r_tx_data;
                        if (r_pair_cnt == LAST_PAIR) begin
                            r_state    <= CHK;
                            r_pair_cnt <= '0;
                            r_tx_data  <= r_chk ^ r_tx_data;
                            r_tx_last  <= 1'b1;
                        end else begin
                            r_pair_cnt <= r_pair_cnt + 1'b1;
                            r_tx_data  <= w_pair_byte;
                        end
                    end
                end
                CHK: begin
                    if (w_xfer) begin
                        r_state    <= IDLE;
                        r_tx_valid <= 1'b0;
                        r_tx_last  <= 1'b0;
                        r_busy     <= 1'b0;
                        r_chk      <= 8'h00;
                        r_tx_data  <= 8'h00;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (SortValid && w_capture) begin
                r_sort_done <= 1'b1;
            end
            if (w_wr_en && (FramAdd == LAST_ADDR)) begin
                r_frame_done <= 1'b1;
            end
            if ((FramEn || SortValid) && !w_capture) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign TxData  = r_tx_data;
    assign TxValid = r_tx_valid;
    assign TxLast  = r_tx_last;
    assign Busy    = r_busy;
    assign Overrun = r_overrun;

endmodule

// File: tb/tb_report_packer.sv
// Scoreboard bench for report_packer: stimulus pushes expected packet bytes,
// a negedge monitor pops and compares every transferred byte.
module tb_report_packer;

    logic       clk = 1'b0;
    logic       rst;
    logic       FramEn;
    logic [5:0] FramAdd;
    logic [3:0] FramData;
    logic       SortValid;
    logic [3:0] MaxCountData1, MaxCountData2, MaxCountData3;
    logic [5:0] MaxCount1, MaxCount2, MaxCount3;
    logic [7:0] TxData;
    logic       TxValid;
    logic       TxReady;
    logic       TxLast;
    logic       Busy;
    logic       Overrun;

    report_packer #(
        .DATA_SIZE  (4),
        .LENGTH     (64),
        .LENGTH_SIZE(6)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .FramEn       (FramEn),
        .FramAdd      (FramAdd),
        .FramData     (FramData),
        .SortValid    (SortValid),
        .MaxCountData1(MaxCountData1),
        .MaxCountData2(MaxCountData2),
        .MaxCountData3(MaxCountData3),
        .MaxCount1    (MaxCount1),
        .MaxCount2    (MaxCount2),
        .MaxCount3    (MaxCount3),
        .TxData       (TxData),
        .TxValid      (TxValid),
        .TxReady      (TxReady),
        .TxLast       (TxLast),
        .Busy         (Busy),
        .Overrun      (Overrun)
    );

    always #5 clk = ~clk;

    int         n_cmp  = 0;
    int         n_bad  = 0;
    int         n_xfer = 0;
    logic [8:0] exp_q[$];
    logic [7:0] ramp_tbl [8] = '{8'h10, 8'h32, 8'h54, 8'h76, 8'h98, 8'hBA, 8'hDC, 8'hFE};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: stall stability and byte-by-byte scoreboard comparison.
    initial begin
        logic       prev_stall;
        logic [7:0] prev_data;
        logic       prev_last;
        logic [8:0] e;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", 32'(TxValid), 32'd1);
                    check("hold_data", 32'(TxData), 32'(prev_data));
                    check("hold_last", 32'(TxLast), 32'(prev_last));
                end
                if (TxValid && TxReady) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_byte: got %02h, expected none", TxData);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("byte%0d {last,data}", n_xfer), 32'({TxLast, TxData}), 32'(e));
                    end
                    n_xfer++;
                end
                prev_stall = TxValid && !TxReady;
                prev_data  = TxData;
                prev_last  = TxLast;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fe, input logic [5:0] a, input logic [3:0] d, input logic sv);
        cyc();
        FramEn    = fe;
        FramAdd   = a;
        FramData  = d;
        SortValid = sv;
    endtask

    task automatic set_res(input logic [47:0] r);
        MaxCountData1 = r[43:40];
        MaxCount1     = r[37:32];
        MaxCountData2 = r[27:24];
        MaxCount2     = r[21:16];
        MaxCountData3 = r[11:8];
        MaxCount3     = r[5:0];
    endtask

    task automatic push_pkt(input logic [47:0] r, input bit ramp, input logic [7:0] chk);
        exp_q.push_back({1'b0, 8'hA5});
        for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, r[47-8*i -: 8]});
        for (int k = 0; k < 32; k++) exp_q.push_back({1'b0, ramp ? ramp_tbl[k%8] : 8'h00});
        exp_q.push_back({1'b1, chk});
    endtask

    task automatic write_frame(input bit ramp, input int last_addr);
        for (int i = 0; i <= last_addr; i++) begin
            drive(1'b1, 6'(i), ramp ? 4'(i % 16) : 4'h0, 1'b0);
        end
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || TxValid) && t < 600) begin
            @(negedge clk);
            t++;
        end
        check(name, 32'(exp_q.size() == 0 && !TxValid), 32'd1);
    endtask

    task automatic wait_xfer(input string name, input int target);
        int t;
        t = 0;
        while (n_xfer < target && t < 300) begin
            @(negedge clk);
            t++;
        end
        check(name, 32'(n_xfer >= target), 32'd1);
    endtask

    localparam logic [47:0] RES_A = {8'h03, 8'h0A, 8'h05, 8'h08, 8'h00, 8'h00};
    localparam logic [47:0] RES_B = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    localparam logic [47:0] RES_D = {8'h07, 8'h01, 8'h02, 8'h09, 8'h04, 8'h00};
    localparam logic [47:0] RES_X = {8'h0F, 8'h3F, 8'h0F, 8'h3F, 8'h0F, 8'h3F};

    initial begin
        int cnt;
        int base;
        int seen;
        rst       = 1'b1;
        FramEn    = 1'b0;
        FramAdd   = '0;
        FramData  = '0;
        SortValid = 1'b0;
        TxReady   = 1'b1;
        set_res('0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_txvalid", 32'(TxValid), 32'd0);
        check("rst_txlast", 32'(TxLast), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_overrun", 32'(Overrun), 32'd0);
        check("rst_txdata", 32'(TxData), 32'h00);
        cyc();
        rst = 1'b0;

        // All-zero frame, results after frame, no back-pressure.
        push_pkt(RES_A, 1'b0, 8'hA1);
        write_frame(1'b0, 63);
        set_res(RES_A);
        drive(1'b0, 6'd0, 4'd0, 1'b1);
        drive(1'b0, 6'd0, 4'd0, 1'b0);
        cnt = 0;
        while (!TxValid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("a_busy", 32'(Busy), 32'd1);
        cnt = 0;
        while (TxValid && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check("a_valid_run", 32'(cnt), 32'd40);
        wait_done("a_done");
        check("a_busy_end", 32'(Busy), 32'd0);

        // Results first, ramp frame; packet one cycle after last write.
        push_pkt(RES_B, 1'b1, 8'hA2);
        set_res(RES_B);
        drive(1'b0, 6'd0, 4'd0, 1'b1);
        write_frame(1'b1, 63);
        drive(1'b0, 6'd0, 4'd0, 1'b0);
        @(negedge clk);
        check("b_lat_pre", 32'(TxValid), 32'd0);
        @(negedge clk);
        check("b_lat_start", 32'(TxValid), 32'd1);
        wait_done("b_done");

        // Zero frame again with TxReady pattern 1,0,0,1.
        push_pkt(RES_A, 1'b0, 8'hA1);
        write_frame(1'b0, 63);
        set_res(RES_A);
        drive(1'b0, 6'd0, 4'd0, 1'b1);
        drive(1'b0, 6'd0, 4'd0, 1'b0);
        cnt = 0;
        while ((exp_q.size() != 0 || TxValid || cnt < 2) && cnt < 800) begin
            cyc();
            TxReady = (cnt % 4 == 0) || (cnt % 4 == 3);
            cnt++;
        end
        TxReady = 1'b1;
        check("c_done", 32'(exp_q.size() == 0 && !TxValid), 32'd1);

        // SortValid with the last write; FramEn during FRM is ignored.
        push_pkt(RES_D, 1'b1, 8'hAC);
        write_frame(1'b1, 62);
        set_res(RES_D);
        base = n_xfer;
        drive(1'b1, 6'd63, 4'hF, 1'b1);
        drive(1'b0, 6'd0, 4'd0, 1'b0);
        @(negedge clk);
        check("d_lat_pre", 32'(TxValid), 32'd0);
        @(negedge clk);
        check("d_lat_start", 32'(TxValid), 32'd1);
        check("d_ovr_before", 32'(Overrun), 32'd0);
        wait_xfer("d_reach_frm", base + 9);
        drive(1'b1, 6'd61, 4'hF, 1'b0);
        drive(1'b0, 6'd0, 4'd0, 1'b0);
        @(negedge clk);
        check("d_ovr_set", 32'(Overrun), 32'd1);
        wait_done("d_done");
        check("d_ovr_sticky", 32'(Overrun), 32'd1);

        // Reset mid-packet, partial frame, then a fresh packet.
        push_pkt(RES_A, 1'b0, 8'hA1);
        write_frame(1'b0, 63);
        set_res(RES_A);
        base = n_xfer;
        drive(1'b0, 6'd0, 4'd0, 1'b1);
        drive(1'b0, 6'd0, 4'd0, 1'b0);
        wait_xfer("e_reach_20", base + 20);
        cyc();
        rst = 1'b1;
        exp_q.delete();
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("e_rst_txvalid", 32'(TxValid), 32'd0);
        check("e_rst_busy", 32'(Busy), 32'd0);
        check("e_rst_overrun", 32'(Overrun), 32'd0);
        set_res(RES_X);
        drive(1'b0, 6'd0, 4'd0, 1'b1);
        write_frame(1'b0, 40);
        drive(1'b0, 6'd0, 4'd0, 1'b0);
        seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (TxValid) seen = 1;
        end
        check("e_partial_nopkt", 32'(seen), 32'd0);
        push_pkt(RES_B, 1'b1, 8'hA2);
        set_res(RES_B);
        drive(1'b0, 6'd0, 4'd0, 1'b1);
        write_frame(1'b1, 63);
        drive(1'b0, 6'd0, 4'd0, 1'b0);
        wait_done("e_done");

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

endmodule
